// File: rtl/timestep_seq_pkg.sv
// timestep_seq_pkg: shared state encoding and default step count for the timestep sequencer.
package timestep_seq_pkg;
    localparam int NSTEPS_DEFAULT = 11;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
endpackage

// File: rtl/timestep_seq_step_dec.sv
// step_dec: binary step index to one-hot decode, bit 0 on the MSB side; out-of-range indices give all zeros.
module step_dec #(
    parameter int N = 11,
    parameter int W = $clog2(N)
) (
    input  logic [W-1:0] idx_i,
    output logic [0:N-1] t_o
);
    for (genvar k = 0; k < N; k++) begin : g_dec
        assign t_o[k] = idx_i == W'(k);
    end
endmodule

// File: rtl/timestep_seq.sv
// timestep_seq: control timestep counter that runs 0..LastQ per instruction, with stall,
// early clear and a one-cycle Done pulse on completion.
module timestep_seq
    import timestep_seq_pkg::*;
#(
    parameter int NSTEPS = NSTEPS_DEFAULT,
    parameter int CW     = $clog2(NSTEPS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          run_i,
    input  logic [CW-1:0] last_i,
    input  logic          stall_i,
    input  logic          clr_i,
    output logic [CW-1:0] count_o,
    output logic [0:NSTEPS-1] t_o,
    output logic          busy_o,
    output logic          done_o
);
    logic [0:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] last_q, last_d;
    logic          done_q, done_d;
    logic [CW-1:0] last_lim;
    // Clamp the requested final step so Count can never leave the decode range.
    assign last_lim = last_i > CW'(NSTEPS - 1) ? CW'(NSTEPS - 1) : last_i;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;
        done_d  = 1'b0;
        if (state_q == S_IDLE) begin
            if (run_i && !clr_i) begin
                last_d = last_lim;
                if (last_lim == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                    count_d = CW'(1);
                end
            end
        end else if (clr_i || (!stall_i && count_q == last_q)) begin
            state_d = S_IDLE;
            count_d = '0;
            done_d  = 1'b1;
        end else if (!stall_i) begin
            count_d = count_q + CW'(1);
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end
    assign count_o = count_q;
    assign busy_o  = state_q == S_RUN;
    assign done_o  = done_q;
    step_dec #(.N(NSTEPS), .W(CW)) u_dec (
        .idx_i(count_q),
        .t_o  (t_o)
    );
endmodule

// File: tb/tb_timestep_seq.sv
// tb_timestep_seq: directed vectors feed a scoreboard queue; a monitor checks each cycle's outputs.
module tb_timestep_seq;
    localparam int NS = 11;
    localparam int W  = 4;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic [W-1:0]  last = '0;
    logic          stall = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  count;
    logic [0:NS-1] t;
    logic          busy;
    logic          done;
    int vectors = 0;
    int miscompares = 0;
    typedef struct {
        string nm;
        int    c;
        bit    d;
        bit    b;
    } exp_t;
    exp_t sb[$];
    timestep_seq #(.NSTEPS(NS)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .run_i  (run),
        .last_i (last),
        .stall_i(stall),
        .clr_i  (clr),
        .count_o(count),
        .t_o    (t),
        .busy_o (busy),
        .done_o (done)
    );
    always #5 clk = ~clk;
    task automatic cyc(input string nm, input bit r, input int l, input bit s, input bit cl,
                       input bit rs, input int ec, input bit ed, input bit eb);
        exp_t e;
        @(negedge clk);
        run = r;
        last = W'(l);
        stall = s;
        clr = cl;
        rst = rs;
        e.nm = nm;
        e.c = ec;
        e.d = ed;
        e.b = eb;
        sb.push_back(e);
    endtask
    task automatic rnd_cyc();
        @(negedge clk);
        run = 1'($urandom);
        last = W'($urandom);
        stall = $urandom_range(0, 3) == 0;
        clr = $urandom_range(0, 7) == 0;
        rst = $urandom_range(0, 31) == 0;
    endtask
    always begin
        @(posedge clk);
        #1;
        if (!$onehot(t) || int'(count) > NS - 1 || (done && busy)) begin
            miscompares++;
            $display("FAIL invariant count=%0d t=%b done=%b busy=%b", count, t, done, busy);
        end
        if (sb.size() > 0) begin
            exp_t e;
            logic [0:NS-1] et;
            e = sb.pop_front();
            et = '0;
            if (e.c < NS) et[e.c] = 1'b1;
            vectors++;
            if (int'(count) != e.c || done != e.d || busy != e.b || t != et) begin
                miscompares++;
                $display("FAIL %s: got count=%0d done=%b busy=%b t=%b, expected count=%0d done=%b busy=%b t=%b",
                         e.nm, count, done, busy, t, e.c, e.d, e.b, et);
            end
        end
    end
    initial begin
        cyc("reset0", 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("reset1", 1, 5, 1, 1, 1, 0, 0, 0);
        cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("l3_s1", 1, 3, 0, 0, 0, 1, 0, 1);
        cyc("l3_s2", 0, 0, 0, 0, 0, 2, 0, 1);
        cyc("l3_s3", 0, 0, 0, 0, 0, 3, 0, 1);
        cyc("l3_done", 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("l3_after", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("l4_s1", 1, 4, 0, 0, 0, 1, 0, 1);
        cyc("l4_s2", 0, 0, 0, 0, 0, 2, 0, 1);
        cyc("l4_stall1", 0, 0, 1, 0, 0, 2, 0, 1);
        cyc("l4_stall2", 0, 0, 1, 0, 0, 2, 0, 1);
        cyc("l4_s3", 0, 0, 0, 0, 0, 3, 0, 1);
        cyc("l4_s4", 0, 0, 0, 0, 0, 4, 0, 1);
        cyc("l4_done", 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("l10_s1", 1, 10, 0, 0, 0, 1, 0, 1);
        for (int i = 2; i <= 5; i++) cyc("l10_step", 0, 0, 0, 0, 0, i, 0, 1);
        cyc("clr_run", 0, 0, 0, 1, 0, 0, 1, 0);
        cyc("rerun_s1", 1, 2, 0, 0, 0, 1, 0, 1);
        cyc("rerun_s2", 0, 0, 0, 0, 0, 2, 0, 1);
        cyc("rerun_done", 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("l5_s1", 1, 5, 0, 0, 0, 1, 0, 1);
        cyc("clr_stall", 0, 0, 1, 1, 0, 0, 1, 0);
        cyc("clr_idle", 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("run_clr_idle", 1, 3, 0, 1, 0, 0, 0, 0);
        cyc("after_run_clr", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("l0_done", 1, 0, 0, 0, 0, 0, 1, 0);
        cyc("l0_after", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("l15_s1", 1, 15, 0, 0, 0, 1, 0, 1);
        for (int i = 2; i <= 10; i++) cyc("l15_step", 0, 0, 0, 0, 0, i, 0, 1);
        cyc("l15_done", 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("l2_s1", 1, 2, 0, 0, 0, 1, 0, 1);
        cyc("run_in_run", 1, 9, 0, 0, 0, 2, 0, 1);
        cyc("l2_done", 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("l1_s1", 1, 1, 0, 0, 0, 1, 0, 1);
        cyc("l1_stall", 0, 0, 1, 0, 0, 1, 0, 1);
        cyc("l1_done", 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("rst_s1", 1, 10, 0, 0, 0, 1, 0, 1);
        for (int i = 2; i <= 6; i++) cyc("rst_step", 0, 0, 0, 0, 0, i, 0, 1);
        cyc("rst_mid", 1, 3, 0, 0, 1, 0, 0, 0);
        cyc("rst_nodone", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) rnd_cyc();
        cyc("rnd_reset", 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("rnd_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/timestep_seq.md
TIMESTEP_SEQ -- requirements
Module: timestep_seq

Interface
REQ-001 Parameter NSTEPS, default 11: number of control timesteps, legal range 2..32.
REQ-002 Parameter CW, default $clog2(NSTEPS): counter width.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Run  input  1  start request, sampled only in IDLE.
REQ-006 Last  input  CW  final step index for the instruction, sampled with an accepted Run.
REQ-007 Stall  input  1  holds the current step while high.
REQ-008 Clr  input  1  early-terminate request; forces a return to step 0.
REQ-009 Count  output  CW  current step index, registered.
REQ-010 T  output  [0:NSTEPS-1]  one-hot step decode of Count, with T[0] as the MSB-side bit.
REQ-011 Busy  output  1  high while in RUN.
REQ-012 Done  output  1  one-cycle registered pulse on completion or termination.

Function
REQ-013 Two states SHALL exist: IDLE (Count=0) and RUN.
REQ-014 T SHALL be combinational from Count: T[k]=1 if and only if Count==k, with exactly one bit set at all times.
REQ-015 In IDLE, Run=1 SHALL latch LastQ=min(Last,NSTEPS-1); if LastQ>0, the next state SHALL be RUN with Count=1.
REQ-016 In IDLE, Run=1 with Last=0 SHALL leave Count=0, keep the state IDLE, and pulse Done the next cycle.
REQ-017 In RUN with Stall=0 and Count<LastQ, Count SHALL increment by 1 per cycle.
REQ-018 In RUN with Stall=0 and Count==LastQ, the next cycle SHALL have Count=0, state IDLE, and Done=1.
REQ-019 In RUN with Stall=1, Count and the state SHALL hold and Done SHALL be 0.
REQ-020 Clr=1 in RUN SHALL force Count=0, state IDLE, and Done=1 the next cycle, regardless of Stall.
REQ-021 Clr=1 in IDLE SHALL have no effect; an accepted Run with Clr=1 in the same cycle SHALL be ignored.
REQ-022 Priority SHALL be Reset > Clr > Stall > advance.
REQ-023 Count SHALL never exceed NSTEPS-1; no wrap-around SHALL occur other than the return to 0 in REQ-018 and REQ-020.
REQ-024 Run while in RUN SHALL be ignored; LastQ SHALL be stable for the entire RUN.
REQ-025 Done SHALL be high for exactly one cycle per completion; Busy SHALL equal (state==RUN).
REQ-026 Instruction latency SHALL be LastQ+1 cycles from Run acceptance to Done with no stalls, plus one cycle per stalled cycle.

Reset
REQ-027 Reset SHALL set state=IDLE, Count=0, LastQ=0, Done=0, and Busy=0, giving T[0]=1.
REQ-028 Reset asserted mid-RUN SHALL abort without a Done pulse.
REQ-029 Reset SHALL override every other input in the same cycle.

Structure
REQ-030 The shared package SHALL hold the state encoding (IDLE=0, RUN=1) and the default NSTEPS=11.
REQ-031 One sub-module, step_dec, SHALL implement the parametrised CW-to-one-hot decode.
REQ-032 step_dec SHALL output all zeros for out-of-range inputs.
REQ-033 The block SHALL contain no latches; all registers SHALL be in a single clocked process.

Verification
REQ-034 Reset, then Run=1 with Last=3 and no stall -> Count sequence 1,2,3,0; Done high in the cycle Count returns to 0; T shows 0100..., 0010..., 0001..., 1000....
REQ-035 Run with Last=4 and Stall=1 for 2 cycles at Count=2 -> Count sequence 1,2,2,2,3,4,0; total latency 7 cycles.
REQ-036 Run with Last=10, then Clr=1 at Count=5 -> next cycle Count=0 and Done=1; a subsequent Run is accepted normally.
REQ-037 Run with Last=0 -> Count stays 0, Busy stays 0, Done pulses once; Run with Last=15 at NSTEPS=11 -> terminates after Count=10.
REQ-038 Reset asserted at Count=6 -> Count=0 next cycle with no Done pulse.
REQ-039 Random stimulus with assertions -> T one-hot in every cycle; Done width always 1 cycle; Count never exceeds NSTEPS-1.
